// File: rtl/rv32_exec_slice.sv
`default_nettype none
// ============================================================================
// Module  : rv32_exec_slice
// Brief   : RV32 execution slice: 32x32 regfile, one-hot ALU, 3:8 decoder.
// Revision: 1.0
// ============================================================================
module rv32_exec_slice #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int OPW   = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wen,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  input  logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] alu_result,
  input  logic [2:0]      dec_in,
  output logic [7:0]      dec_out
);

  localparam int c_SHAMT_W = $clog2(XLEN);

  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wen && (waddr != 5'd0)) begin
      r_regs[waddr] <= wdata;
    end
  end

  // No write bypass: a same-cycle write becomes visible only after the edge.
  assign rdata1 = (raddr1 == 5'd0) ? '0 : r_regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : r_regs[raddr2];

  logic [c_SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]      w_op_res [OPW];
  logic [XLEN-1:0]      w_result;

  assign w_shamt = alu_src2[c_SHAMT_W-1:0];

  always_comb begin
    for (int i = 0; i < OPW; i++) begin
      w_op_res[i] = '0;
    end
    w_op_res[0] = alu_src1 + alu_src2;
    w_op_res[1] = alu_src1 - alu_src2;
    w_op_res[2] = alu_src1 & alu_src2;
    w_op_res[3] = alu_src1 | alu_src2;
    w_op_res[4] = alu_src1 ^ alu_src2;
    w_op_res[5] = alu_src1 << w_shamt;
    w_op_res[6] = alu_src1 >> w_shamt;
    w_op_res[7] = XLEN'($signed(alu_src1) >>> w_shamt);
    w_op_res[8] = {{(XLEN-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
    w_op_res[9] = {{(XLEN-1){1'b0}}, (alu_src1 < alu_src2)};
  end

  // Each select bit gates its own result; multiple selects simply OR together.
  always_comb begin
    w_result = '0;
    for (int i = 0; i < OPW; i++) begin
      w_result = w_result | (w_op_res[i] & {XLEN{alu_op[i]}});
    end
  end

  assign alu_result = w_result;

  for (genvar g = 0; g < 8; g++) begin : g_dec
    assign dec_out[g] = (dec_in == 3'(g));
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_exec_slice.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv32_exec_slice
// Brief   : Directed self-checking bench for rv32_exec_slice.
// Revision: 1.0
// ============================================================================
module tb_rv32_exec_slice;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [9:0]  alu_op;
  logic [31:0] alu_result;
  logic [2:0]  dec_in;
  logic [7:0]  dec_out;

  int n_cmp  = 0;
  int n_fail = 0;

  rv32_exec_slice dut (
    .clk        (clk),
    .reset      (reset),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .dec_in     (dec_in),
    .dec_out    (dec_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  localparam int c_NVEC = 17;
  alu_vec_t vecs [c_NVEC];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{10'h001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[1]  = '{10'h001, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C};
    vecs[2]  = '{10'h002, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[3]  = '{10'h004, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
    vecs[4]  = '{10'h008, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0};
    vecs[5]  = '{10'h010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00};
    vecs[6]  = '{10'h000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};
    vecs[7]  = '{10'h020, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
    vecs[8]  = '{10'h040, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
    vecs[9]  = '{10'h080, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF};
    vecs[10] = '{10'h080, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
    vecs[11] = '{10'h040, 32'hF000_0000, 32'h0000_0024, 32'h0F00_0000};
    vecs[12] = '{10'h100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[13] = '{10'h200, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[14] = '{10'h100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[15] = '{10'h200, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[16] = '{10'h011, 32'h0000_0003, 32'h0000_0005, 32'h0000_000E};

    reset = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0;
    alu_src1 = '0; alu_src2 = '0; alu_op = '0; dec_in = '0;

    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      check($sformatf("reset_rd1_x%0d", i), rdata1, 32'h0);
      check($sformatf("reset_rd2_x%0d", 31 - i), rdata2, 32'h0);
    end

    // x0 write is discarded
    wen = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF; raddr1 = 5'd0;
    tick();
    wen = 1'b0;
    #1;
    check("x0_write_ignored", rdata1, 32'h0);

    // read-during-write returns old value, new value after the edge
    wen = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; raddr1 = 5'd5;
    #1;
    check("rdw_old_value", rdata1, 32'h0);
    tick();
    wen = 1'b0;
    #1;
    check("rdw_new_value", rdata1, 32'h1234_5678);

    wdata = 32'hFFFF_FFFF; waddr = 5'd5; wen = 1'b0;
    tick();
    check("wen0_holds", rdata1, 32'h1234_5678);

    // reset wins over a simultaneous write
    reset = 1'b1; wen = 1'b1; waddr = 5'd5; wdata = 32'hAAAA_5555;
    tick();
    reset = 1'b0; wen = 1'b0;
    #1;
    check("reset_over_write", rdata1, 32'h0);

    // dual port
    wen = 1'b1; waddr = 5'd1; wdata = 32'h8000_0000;
    tick();
    waddr = 5'd2; wdata = 32'h0000_0004;
    tick();
    waddr = 5'd31; wdata = 32'hCAFE_F00D;
    tick();
    wen = 1'b0;
    raddr1 = 5'd1; raddr2 = 5'd2;
    #1;
    check("dual_rd1_x1", rdata1, 32'h8000_0000);
    check("dual_rd2_x2", rdata2, 32'h0000_0004);
    raddr1 = 5'd31; raddr2 = 5'd1;
    #1;
    check("dual_rd1_x31", rdata1, 32'hCAFE_F00D);
    check("dual_rd2_x1", rdata2, 32'h8000_0000);

    // ALU vector table
    for (int i = 0; i < c_NVEC; i++) begin
      alu_op = vecs[i].op; alu_src1 = vecs[i].a; alu_src2 = vecs[i].b;
      #1;
      check($sformatf("alu_vec%0d_op%03h", i, vecs[i].op), alu_result, vecs[i].exp);
    end

    // decoder sweep
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_dec;
      exp_dec = 8'h01 << i;
      dec_in = 3'(i);
      #1;
      check($sformatf("dec_in%0d", i), {24'h0, dec_out}, {24'h0, exp_dec});
      check($sformatf("dec_onehot%0d", i), 32'($countones(dec_out)), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
